// File: rtl/scan_sequencer.sv
// Round-robin channel scanner driving a 2-to-4 enable decoder.
// Ports: clk, rst_n, run, hold, mask[3:0] -> sel[1:0], en, frame_done.
module scan_sequencer #(
    parameter int CNT_W     = 16,
    parameter int ON_CYC    = 4,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       hold,
    input  logic [3:0] mask,
    output logic [1:0] sel,
    output logic       en,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

    localparam logic [CNT_W-1:0] ON_LD =
        CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] BL_LD =
        CNT_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       nxt;
    logic [1:0]       low;
    logic [1:0]       idx;
    logic             wrap;
    logic             adv;

    // nxt: first set bit strictly after sel (cyclic); falls back to sel
    // itself, which is right when sel is the only set bit.
    always_comb begin
        nxt = sel;
        idx = sel;
        for (int k = 3; k >= 1; k--) begin
            idx = sel + 2'(k);
            if (mask[idx]) nxt = idx;
        end
        low = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) low = 2'(k);
        end
        wrap = (nxt <= sel);
        adv  = ((state == ON) && (cnt == '0) && (BLANK_CYC == 0))
            || ((state == BLANK) && (cnt == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 2'd0;
            en         <= 1'b0;
            frame_done <= 1'b0;
        end else if (hold) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state != IDLE && !run) begin
                state <= IDLE;
                en    <= 1'b0;
            end else if (adv) begin
                if (mask == 4'd0) begin
                    state <= IDLE;
                    en    <= 1'b0;
                end else begin
                    state      <= ON;
                    sel        <= nxt;
                    en         <= 1'b1;
                    cnt        <= ON_LD;
                    frame_done <= wrap;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (run && mask != 4'd0) begin
                            state <= ON;
                            sel   <= low;
                            en    <= 1'b1;
                            cnt   <= ON_LD;
                        end
                    end
                    ON: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state <= BLANK;
                            en    <= 1'b0;
                            cnt   <= BL_LD;
                        end
                    end
                    BLANK: cnt <= cnt - 1'b1;
                    default: begin
                        state <= IDLE;
                        en    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer.
// Stimulus queues per-cycle expectations; a monitor pops and compares.
module tb_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       hold;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en;
    logic       frame_done;

    typedef struct {
        logic [1:0] s;
        logic       e;
        logic       f;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    scan_sequencer #(.CNT_W(16), .ON_CYC(4), .BLANK_CYC(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .hold(hold),
        .mask(mask),
        .sel(sel),
        .en(en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [1:0] es, input logic ee,
                        input logic ef);
        exp_t x;
        x.s = es;
        x.e = ee;
        x.f = ef;
        q.push_back(x);
    endtask

    // Drive one cycle of inputs; expectation is the state after next edge.
    task automatic step(input logic r, input logic h,
                        input logic [3:0] m, input logic [1:0] es,
                        input logic ee, input logic ef);
        @(negedge clk);
        run  = r;
        hold = h;
        mask = m;
        push(es, ee, ef);
    endtask

    // One full slot: 4 clocks enabled, 2 clocks blanked.
    task automatic slot(input logic [1:0] s, input logic fd,
                        input logic [3:0] m);
        step(1, 0, m, s, 1, fd);
        repeat (3) step(1, 0, m, s, 1, 0);
        repeat (2) step(1, 0, m, s, 0, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (sel !== e.s || en !== e.e || frame_done !== e.f) begin
                    bad++;
                    $display("FAIL chk%0d t=%0t got sel=%0d en=%b fd=%b want sel=%0d en=%b fd=%b",
                             total, $time, sel, en, frame_done,
                             e.s, e.e, e.f);
                end
            end
            if (done) begin
                total++;
                if (q.size() != 0) begin
                    bad++;
                    $display("FAIL drain got %0d pending want 0", q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        hold  = 1'b0;
        mask  = 4'd0;
        repeat (2) step(0, 0, 4'h0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 4'hF, 0, 0, 0);

        // full mask round robin, frame_done when sel returns to 0
        slot(0, 0, 4'hF);
        slot(1, 0, 4'hF);
        slot(2, 0, 4'hF);
        slot(3, 0, 4'hF);
        slot(0, 1, 4'hF);
        slot(1, 0, 4'hF);

        // alternating channels 1 and 3
        slot(3, 0, 4'hA);
        slot(1, 1, 4'hA);

        // hold during ON with counter=2, then hold at the advance edge
        step(1, 0, 4'hA, 3, 1, 0);
        step(1, 0, 4'hA, 3, 1, 0);
        repeat (5) step(1, 1, 4'hA, 3, 1, 0);
        step(1, 0, 4'hA, 3, 1, 0);
        step(1, 0, 4'hA, 3, 1, 0);
        step(1, 0, 4'hA, 3, 0, 0);
        step(1, 0, 4'hA, 3, 0, 0);
        step(1, 1, 4'hA, 3, 0, 0);
        step(1, 0, 4'hA, 1, 1, 1);
        repeat (3) step(1, 0, 4'hA, 1, 1, 0);
        repeat (2) step(1, 0, 4'hA, 1, 0, 0);

        // run dropped in BLANK with sel=2, then restart on single channel
        repeat (4) step(1, 0, 4'h4, 2, 1, 0);
        step(1, 0, 4'h4, 2, 0, 0);
        step(0, 0, 4'h4, 2, 0, 0);
        step(0, 0, 4'h4, 2, 0, 0);
        step(1, 0, 4'h4, 2, 1, 0);
        repeat (3) step(1, 0, 4'h4, 2, 1, 0);
        repeat (2) step(1, 0, 4'h4, 2, 0, 0);
        slot(2, 1, 4'h4);

        // mask cleared during channel 1 slot
        step(1, 0, 4'h2, 1, 1, 1);
        repeat (3) step(1, 0, 4'h0, 1, 1, 0);
        repeat (2) step(1, 0, 4'h0, 1, 0, 0);
        step(1, 0, 4'h0, 1, 0, 0);
        step(1, 0, 4'h0, 1, 0, 0);

        // run and hold together in IDLE: stay idle
        step(1, 1, 4'h8, 1, 0, 0);
        step(1, 0, 4'h8, 3, 1, 0);
        step(1, 0, 4'h8, 3, 1, 0);

        // async reset pulse mid-slot, released before the next edge
        @(negedge clk);
        run   = 1'b0;
        rst_n = 1'b0;
        push(0, 0, 0);
        #2;
        rst_n = 1'b1;
        step(0, 0, 4'hF, 0, 0, 0);
        step(1, 0, 4'hF, 0, 1, 0);
        step(1, 0, 4'hF, 0, 1, 0);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end
endmodule
